single_cycle: RTL and testbench
===============================

Name: single_cycle

Overview:
- Single-cycle ARMv8 (LEGv8 subset) processor core: one instruction fetched, decoded, executed and retired per clock.
- Contains a fixed instruction ROM, a 32x64 register file and a 32x64 data memory.
- Exposes the PC and a registered load-data port for system-level checking.

Parameters:
- DMEM_WORDS, 32, data memory depth in 64-bit words (byte address bits [7:3]).
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words (byte address bits [7:2]).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- resetl  in  1  synchronous, active-high reset (the port name is kept as-is; 1 = reset).
- startpc  in  64  PC value loaded during reset.
- currentpc  out  64  PC of the instruction currently executing.
- dmemout  out  64  registered read data of the most recent LDUR.

Behaviour:
- Reset (resetl=1 at a rising edge):
  - PC <= startpc; dmemout <= 0; X0..X30 <= 0.
  - Data memory reloads its initial image: word0=1, word1=0xA, word2=5, word3=0x0FFBEA7DEADBEEFF, all other words 0.
  - Reset mid-run aborts the current instruction; no register or memory write occurs that cycle.
- X31 = XZR: reads return 0, writes are discarded.
- Per rising edge (not in reset), the instruction at ROM[PC[7:2]] executes:
  - LDUR (opc[31:21]=0x7C2): address = Xn + sign-extended imm9[20:12]. Rt <= mem; dmemout <= mem[addr[7:3]].
  - STUR (0x7C0): mem[addr[7:3]] <= Rt.
  - ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550: Rd <= Rn op Rm, 64-bit wrap-around, no flags.
  - MOVZ (opc[31:23]=0x1A5): Rd <= imm16 << (16*hw[22:21]).
  - CBZ (opc[31:24]=0xB4): if Rt==0, PC <= PC + 4*sext(imm19[23:5]).
  - B (opc[31:26]=0x05): PC <= PC + 4*sext(imm26).
  - All other instructions: PC <= PC+4.
  - Any unrecognised encoding is a NOP (PC+4).
- dmemout holds its value on non-LDUR cycles. LDUR data is visible one edge after PC reaches the LDUR.
- Data memory write is synchronous. A read in a later cycle sees the written value. Addresses use bits [7:3] only; higher address bits are ignored.
- ROM contents, fixed (unlisted addresses = NOP):
  - 00 LDUR X9,[XZR,#0]
  - 04 LDUR X10,[XZR,#8]
  - 08 LDUR X11,[XZR,#16]
  - 0C LDUR X12,[XZR,#24]
  - 10 LDUR X13,[XZR,#32]
  - 14 ORR X10,X10,X11
  - 18 AND X12,X12,X10
  - 1C CBZ X13,+2
  - 20 ADD X12,X12,X9
  - 24 STUR X12,[X13,#40]
  - 28 ADD X9,X9,XZR
  - 2C SUB X14,X10,X12
  - 30 LDUR X15,[X13,#40]
  - 34 MOVZ X9,#0x1234,LSL48
  - 38 MOVZ X10,#0x5678,LSL32
  - 3C ORR X9,X9,X10
  - 40 MOVZ X10,#0x9ABC,LSL16
  - 44 ORR X9,X9,X10
  - 48 MOVZ X10,#0xDEF0
  - 4C ORR X9,X9,X10
  - 50 STUR X9,[XZR,#48]
  - 54 LDUR X11,[XZR,#48]
  - 58 B #0 (halt: PC stays 0x58)
- Expected results:
  - Program 1 leaves 0xF at mem word5.
  - Program 2 leaves 0x123456789ABCDEF0 at word6.

Decomposition:
- Shared package: opcode constants (LDUR/STUR/ADD/SUB/AND/ORR/MOVZ/CBZ/B) and an ALU-op enum.
- One natural sub-module: single_cycle_regfile (2 read ports, 1 write port, XZR handling, sync clear on reset).
- Control decode, ALU, ROM and data memory stay in the top.

Test Plan:
- Reset with startpc=0, run until currentpc=0x30, clock once more -> dmemout=0x000000000000000F, currentpc=0x34.
- Continue until currentpc=0x54, clock once more -> dmemout=0x123456789ABCDEF0.
- CBZ taken check: currentpc sequence goes 0x1C -> 0x24 (0x20 never appears). Program 1 result is 0xF, not 0x10.
- After 0x58, run 10 cycles -> currentpc stays 0x58 and dmemout stays 0x123456789ABCDEF0.
- Reset with startpc=0x34 -> PC=0x34 on the next edge. At the 0x54 LDUR, dmemout=0x123456789ABCDEF0.
- Assert resetl while PC=0x20 -> next edge PC=startpc and dmemout=0. A rerun of program 1 still yields 0xF.

Source files
------------

// File: rtl/single_cycle_pkg.sv
// Shared LEGv8 opcode constants, instruction classes, ALU ops and the data-memory power-on image.
// Pure declarations: no latency, no backpressure.
package single_cycle_pkg;

    typedef logic [63:0] xword_t;

    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [8:0]  OPC_MOVZ = 9'h1A5;
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;
    localparam logic [5:0]  OPC_B    = 6'h05;

    localparam logic [4:0]  XZR      = 5'd31;

    typedef enum logic [2:0] {
        I_NOP,
        I_LDUR,
        I_STUR,
        I_RTYPE,
        I_MOVZ,
        I_CBZ,
        I_B
    } inst_kind_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR
    } alu_op_t;

    // Anything not matching a supported encoding falls through to NOP.
    function automatic inst_kind_t decode_kind(input logic [31:0] instr);
        if (instr[31:21] == OPC_LDUR) return I_LDUR;
        if (instr[31:21] == OPC_STUR) return I_STUR;
        if (instr[31:21] == OPC_ADD || instr[31:21] == OPC_SUB ||
            instr[31:21] == OPC_AND || instr[31:21] == OPC_ORR) return I_RTYPE;
        if (instr[31:23] == OPC_MOVZ) return I_MOVZ;
        if (instr[31:24] == OPC_CBZ)  return I_CBZ;
        if (instr[31:26] == OPC_B)    return I_B;
        return I_NOP;
    endfunction

    function automatic alu_op_t rtype_op(input logic [10:0] opc);
        case (opc)
            OPC_SUB: return ALU_SUB;
            OPC_AND: return ALU_AND;
            OPC_ORR: return ALU_ORR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic xword_t dmem_image(input int idx);
        case (idx)
            0:       return 64'h0000_0000_0000_0001;
            1:       return 64'h0000_0000_0000_000A;
            2:       return 64'h0000_0000_0000_0005;
            3:       return 64'h0FFB_EA7D_EADB_EEFF;
            default: return 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/single_cycle_if.sv
// System-visible core signals: start PC in, current PC and registered load data out.
// Plain wires: no latency, no backpressure.
interface single_cycle_if;
    import single_cycle_pkg::*;

    xword_t startpc;
    xword_t currentpc;
    xword_t dmemout;

    modport master (output startpc, input currentpc, input dmemout);
    modport slave  (input startpc, output currentpc, output dmemout);
endinterface

// File: rtl/single_cycle_regfile.sv
// 32x64 register file, 2 combinational read ports, 1 synchronous write port, X31 reads as zero.
// Write lands on the next rising edge; synchronous clear on rst; no backpressure.
module single_cycle_regfile
    import single_cycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rd_addr_a,
    input  logic [4:0] rd_addr_b,
    output xword_t     rd_dat_a,
    output xword_t     rd_dat_b,
    input  logic       wr_vld,
    input  logic [4:0] wr_addr,
    input  xword_t     wr_dat
);

    xword_t regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_vld && wr_addr != XZR) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat_a = (rd_addr_a == XZR) ? '0 : regs[rd_addr_a];
    assign rd_dat_b = (rd_addr_b == XZR) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/single_cycle.sv
// Single-cycle LEGv8-subset core: fixed ROM, register file, data memory; one instruction retires per edge.
// Load data appears on dmemout one edge after PC reaches the LDUR; no backpressure.
module single_cycle
    import single_cycle_pkg::*;
#(
    parameter int DMEM_WORDS = 32,
    parameter int IMEM_WORDS = 64
) (
    input  logic          CLK,
    input  logic          resetl,
    single_cycle_if.slave bus
);

    localparam int DW_BITS = $clog2(DMEM_WORDS);
    localparam int IW_BITS = $clog2(IMEM_WORDS);

    xword_t     pc_q;
    xword_t     dmemout_q;
    xword_t     dmem [DMEM_WORDS];

    logic [31:0] instr;
    inst_kind_t  kind;
    alu_op_t     alu_op;
    logic [4:0]  rf_addr_b;
    xword_t      rf_dat_a;
    xword_t      rf_dat_b;
    xword_t      alu_b;
    xword_t      alu_res;
    xword_t      movz_val;
    xword_t      wb_dat;
    logic        wb_vld;
    xword_t      mem_addr;
    logic [DW_BITS-1:0] dmem_idx;
    xword_t      dmem_rdat;
    xword_t      pc_next;
    xword_t      cb_off;
    xword_t      b_off;
    logic        unused_addr_bits;

    function automatic logic [31:0] rom_word(input logic [IW_BITS-1:0] idx);
        case (int'(idx))
            0:       return 32'hF840_03E9;  // LDUR X9,[XZR,#0]
            1:       return 32'hF840_83EA;  // LDUR X10,[XZR,#8]
            2:       return 32'hF841_03EB;  // LDUR X11,[XZR,#16]
            3:       return 32'hF841_83EC;  // LDUR X12,[XZR,#24]
            4:       return 32'hF842_03ED;  // LDUR X13,[XZR,#32]
            5:       return 32'hAA0B_014A;  // ORR X10,X10,X11
            6:       return 32'h8A0A_018C;  // AND X12,X12,X10
            7:       return 32'hB400_004D;  // CBZ X13,+2
            8:       return 32'h8B09_018C;  // ADD X12,X12,X9
            9:       return 32'hF802_81AC;  // STUR X12,[X13,#40]
            10:      return 32'h8B1F_0129;  // ADD X9,X9,XZR
            11:      return 32'hCB0C_014E;  // SUB X14,X10,X12
            12:      return 32'hF842_81AF;  // LDUR X15,[X13,#40]
            13:      return 32'hD2E2_4689;  // MOVZ X9,#0x1234,LSL48
            14:      return 32'hD2CA_CF0A;  // MOVZ X10,#0x5678,LSL32
            15:      return 32'hAA0A_0129;  // ORR X9,X9,X10
            16:      return 32'hD2B3_578A;  // MOVZ X10,#0x9ABC,LSL16
            17:      return 32'hAA0A_0129;  // ORR X9,X9,X10
            18:      return 32'hD29B_DE0A;  // MOVZ X10,#0xDEF0
            19:      return 32'hAA0A_0129;  // ORR X9,X9,X10
            20:      return 32'hF803_03E9;  // STUR X9,[XZR,#48]
            21:      return 32'hF843_03EB;  // LDUR X11,[XZR,#48]
            22:      return 32'h1400_0000;  // B #0
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign instr = rom_word(pc_q[IW_BITS+1:2]);
    assign kind  = decode_kind(instr);

    // R-type reads Rm on port B; STUR and CBZ need Rt there instead.
    assign rf_addr_b = (kind == I_RTYPE) ? instr[20:16] : instr[4:0];

    single_cycle_regfile u_regfile (
        .clk       (CLK),
        .rst       (resetl),
        .rd_addr_a (instr[9:5]),
        .rd_addr_b (rf_addr_b),
        .rd_dat_a  (rf_dat_a),
        .rd_dat_b  (rf_dat_b),
        .wr_vld    (wb_vld),
        .wr_addr   (instr[4:0]),
        .wr_dat    (wb_dat)
    );

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rf_dat_b;
        case (kind)
            I_LDUR, I_STUR: alu_b  = {{55{instr[20]}}, instr[20:12]};
            I_RTYPE:        alu_op = rtype_op(instr[31:21]);
            default:        ;
        endcase
        case (alu_op)
            ALU_SUB: alu_res = rf_dat_a - alu_b;
            ALU_AND: alu_res = rf_dat_a & alu_b;
            ALU_ORR: alu_res = rf_dat_a | alu_b;
            default: alu_res = rf_dat_a + alu_b;
        endcase
    end

    assign movz_val  = xword_t'(instr[20:5]) << {instr[22:21], 4'b0000};
    assign mem_addr  = alu_res;
    assign dmem_idx  = mem_addr[DW_BITS+2:3];
    assign dmem_rdat = dmem[dmem_idx];
    assign unused_addr_bits = ^{mem_addr[63:DW_BITS+3], mem_addr[2:0]};

    assign wb_vld = (kind == I_LDUR) || (kind == I_RTYPE) || (kind == I_MOVZ);
    assign wb_dat = (kind == I_LDUR) ? dmem_rdat :
                    (kind == I_MOVZ) ? movz_val  : alu_res;

    assign cb_off = {{43{instr[23]}}, instr[23:5], 2'b00};
    assign b_off  = {{36{instr[25]}}, instr[25:0], 2'b00};

    always_comb begin
        pc_next = pc_q + 64'd4;
        if (kind == I_B) begin
            pc_next = pc_q + b_off;
        end else if (kind == I_CBZ && rf_dat_b == '0) begin
            pc_next = pc_q + cb_off;
        end
    end

    // Reset has priority, so the instruction in flight during reset never commits.
    always_ff @(posedge CLK) begin
        if (resetl) begin
            pc_q      <= bus.startpc;
            dmemout_q <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= dmem_image(i);
        end else begin
            pc_q <= pc_next;
            if (kind == I_LDUR) dmemout_q      <= dmem_rdat;
            if (kind == I_STUR) dmem[dmem_idx] <= rf_dat_b;
        end
    end

    assign bus.currentpc = pc_q;
    assign bus.dmemout   = dmemout_q;

endmodule

// File: tb/tb_single_cycle.sv
// Bench for single_cycle: constant checkpoint table, hand-written CBZ/reset sequences,
// and randomized runs compared every cycle against an assembly-level interpreter.
module tb_single_cycle;

    logic CLK = 1'b0;
    logic resetl = 1'b1;

    single_cycle_if sif ();

    single_cycle dut (
        .CLK    (CLK),
        .resetl (resetl),
        .bus    (sif)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference model: the program listing as assembly-level records.
    typedef enum int {M_NOP, M_LDUR, M_STUR, M_ADD, M_SUB, M_AND, M_ORR, M_MOVZ, M_CBZ, M_B} mkind_t;
    typedef struct {
        mkind_t kind;
        int     d;
        int     n;
        int     m;
        longint imm;
        int     sh;
    } minstr_t;

    localparam int PROG_LEN = 23;
    minstr_t prog [PROG_LEN];

    longint unsigned m_pc;
    longint unsigned m_dout;
    longint unsigned m_x   [32];
    longint unsigned m_mem [32];

    function automatic longint unsigned xr(input int r);
        return (r == 31) ? 64'd0 : m_x[r];
    endfunction

    task automatic wx(input int r, input longint unsigned v);
        if (r != 31) m_x[r] = v;
    endtask

    task automatic model_reset(input longint unsigned sp);
        m_pc   = sp;
        m_dout = 0;
        foreach (m_x[i])   m_x[i]   = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        m_mem[0] = 64'h1;
        m_mem[1] = 64'hA;
        m_mem[2] = 64'h5;
        m_mem[3] = 64'h0FFBEA7DEADBEEFF;
    endtask

    task automatic model_step();
        minstr_t in;
        longint unsigned a;
        int idx;
        idx = int'((m_pc / 4) % 64);
        in.kind = M_NOP; in.d = 0; in.n = 0; in.m = 0; in.imm = 0; in.sh = 0;
        if (idx < PROG_LEN) in = prog[idx];
        a = xr(in.n) + longint'(in.imm);
        case (in.kind)
            M_LDUR: begin m_dout = m_mem[(a / 8) % 32]; wx(in.d, m_dout); end
            M_STUR: m_mem[(a / 8) % 32] = xr(in.d);
            M_ADD:  wx(in.d, xr(in.n) + xr(in.m));
            M_SUB:  wx(in.d, xr(in.n) - xr(in.m));
            M_AND:  wx(in.d, xr(in.n) & xr(in.m));
            M_ORR:  wx(in.d, xr(in.n) | xr(in.m));
            M_MOVZ: wx(in.d, longint'(in.imm) << in.sh);
            default: ;
        endcase
        if (in.kind == M_B || (in.kind == M_CBZ && xr(in.d) == 0))
            m_pc = m_pc + longint'(in.imm * 4);
        else
            m_pc = m_pc + 4;
    endtask

    task automatic tick();
        logic r;
        r = resetl;
        @(posedge CLK);
        #1;
        if (r) model_reset(sif.startpc);
        else   model_step();
    endtask

    task automatic apply_reset(input logic [63:0] sp);
        sif.startpc = sp;
        resetl = 1'b1;
        tick();
        resetl = 1'b0;
        check("reset_pc", sif.currentpc, sp);
        check("reset_dout", sif.dmemout, 64'h0);
    endtask

    task automatic run_until(input logic [63:0] target, input string name);
        int n;
        n = 0;
        while (sif.currentpc !== target && n < 200) begin
            tick();
            n++;
        end
        check({name, "_reach_pc"}, sif.currentpc, target);
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] p;
        logic [63:0] hi;
        p = 64'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 3) == 0) begin
            hi = {$urandom, $urandom};
            p  = {hi[63:8], p[7:0]};
        end
        return p;
    endfunction

    typedef struct {
        bit          do_reset;
        logic [63:0] sp;
        logic [63:0] stop_pc;
        int          extra;
        logic [63:0] exp_pc;
        logic [63:0] exp_dout;
        string       name;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [63:0] prev;
        logic        saw20;
        int          ncyc;

        prog[0]  = '{M_LDUR, 9, 31, 0, 0, 0};
        prog[1]  = '{M_LDUR, 10, 31, 0, 8, 0};
        prog[2]  = '{M_LDUR, 11, 31, 0, 16, 0};
        prog[3]  = '{M_LDUR, 12, 31, 0, 24, 0};
        prog[4]  = '{M_LDUR, 13, 31, 0, 32, 0};
        prog[5]  = '{M_ORR, 10, 10, 11, 0, 0};
        prog[6]  = '{M_AND, 12, 12, 10, 0, 0};
        prog[7]  = '{M_CBZ, 13, 0, 0, 2, 0};
        prog[8]  = '{M_ADD, 12, 12, 9, 0, 0};
        prog[9]  = '{M_STUR, 12, 13, 0, 40, 0};
        prog[10] = '{M_ADD, 9, 9, 31, 0, 0};
        prog[11] = '{M_SUB, 14, 10, 12, 0, 0};
        prog[12] = '{M_LDUR, 15, 13, 0, 40, 0};
        prog[13] = '{M_MOVZ, 9, 0, 0, 64'h1234, 48};
        prog[14] = '{M_MOVZ, 10, 0, 0, 64'h5678, 32};
        prog[15] = '{M_ORR, 9, 9, 10, 0, 0};
        prog[16] = '{M_MOVZ, 10, 0, 0, 64'h9ABC, 16};
        prog[17] = '{M_ORR, 9, 9, 10, 0, 0};
        prog[18] = '{M_MOVZ, 10, 0, 0, 64'hDEF0, 0};
        prog[19] = '{M_ORR, 9, 9, 10, 0, 0};
        prog[20] = '{M_STUR, 9, 31, 0, 48, 0};
        prog[21] = '{M_LDUR, 11, 31, 0, 48, 0};
        prog[22] = '{M_B, 0, 0, 0, 0, 0};

        vecs[0] = '{1'b1, 64'h0,  64'h30, 1,  64'h34, 64'h000000000000000F, "prog1"};
        vecs[1] = '{1'b0, 64'h0,  64'h54, 1,  64'h58, 64'h123456789ABCDEF0, "prog2"};
        vecs[2] = '{1'b0, 64'h0,  64'h58, 10, 64'h58, 64'h123456789ABCDEF0, "halt"};
        vecs[3] = '{1'b1, 64'h34, 64'h54, 1,  64'h58, 64'h123456789ABCDEF0, "start34"};

        sif.startpc = 64'h0;
        model_reset(64'h0);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].do_reset) apply_reset(vecs[i].sp);
            run_until(vecs[i].stop_pc, vecs[i].name);
            repeat (vecs[i].extra) tick();
            check({vecs[i].name, "_pc"}, sif.currentpc, vecs[i].exp_pc);
            check({vecs[i].name, "_dout"}, sif.dmemout, vecs[i].exp_dout);
        end

        // CBZ at 0x1C is taken, so 0x20 must never be fetched.
        apply_reset(64'h0);
        saw20 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            prev = sif.currentpc;
            tick();
            if (sif.currentpc === 64'h20) saw20 = 1'b1;
            if (prev === 64'h1C) check("cbz_target", sif.currentpc, 64'h24);
        end
        check("cbz_skips_0x20", {63'b0, saw20}, 64'h0);

        // Reset asserted while executing 0x20, then program 1 reruns cleanly.
        apply_reset(64'h20);
        check("at_0x20", sif.currentpc, 64'h20);
        sif.startpc = 64'h0;
        resetl = 1'b1;
        tick();
        resetl = 1'b0;
        check("midreset_pc", sif.currentpc, 64'h0);
        check("midreset_dout", sif.dmemout, 64'h0);
        run_until(64'h30, "rerun");
        tick();
        check("rerun_dout", sif.dmemout, 64'hF);

        // Random start points and random mid-run resets against the model.
        for (int r = 0; r < 40; r++) begin
            apply_reset(rand_pc());
            ncyc = $urandom_range(5, 60);
            for (int c = 0; c < ncyc; c++) begin
                if ($urandom_range(0, 39) == 0) begin
                    sif.startpc = rand_pc();
                    resetl = 1'b1;
                end
                tick();
                resetl = 1'b0;
                check("rand_pc", sif.currentpc, m_pc);
                check("rand_dout", sif.dmemout, m_dout);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
